io_arbiter: RTL and testbench

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_arbiter.sv | 131 +++++++++++++
 tb/tb_io_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// Two-master round-robin arbiter in front of one IO slave, one transaction outstanding.
// Define IO_ARB_TIMEOUT_EN to build the DATA-state watchdog (limit TIMEOUT_CYCLES).
module io_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_req_ack,
    output logic        m0_data_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_req_ack,
    output logic        m1_data_ack,
    output logic [31:0] m1_rdata,

    output logic        io_req,
    output logic        io_wr,
    output logic [3:0]  io_wen,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic        io_req_ack,
    input  logic        io_data_ack,
    input  logic [31:0] io_rdata,

    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   gnt;
    logic   prio;
    logic   sel_req;
    logic   expire;
    logic   data_done;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("io_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    assign sel_req = gnt ? m1_req : m0_req;

`ifdef IO_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog;

    // Counter reads 0 on the first DATA cycle, so expiry lands on DATA cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (state != DATA) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 16'd1;
        end
    end

    assign expire = (state == DATA) && (wdog == WDOG_LAST) && !io_data_ack;
`else
    assign expire = 1'b0;
`endif

    assign data_done = (state == DATA) && (io_data_ack || expire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
            prio  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt   <= (m0_req && m1_req) ? prio : m1_req;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (io_req && io_req_ack) begin
                        state <= DATA;
                    end else if (!sel_req) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (data_done) begin
                        state <= IDLE;
                        prio  <= ~gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_req   = (state == REQ) && sel_req;
    assign io_wr    = gnt ? m1_wr    : m0_wr;
    assign io_wen   = gnt ? m1_wen   : m0_wen;
    assign io_addr  = gnt ? m1_addr  : m0_addr;
    assign io_wdata = gnt ? m1_wdata : m0_wdata;

    // Acks are steered only to the granted master; the other one never sees them.
    assign m0_req_ack  = io_req_ack && (state == REQ) && !gnt;
    assign m1_req_ack  = io_req_ack && (state == REQ) &&  gnt;
    assign m0_data_ack = data_done && !gnt;
    assign m1_data_ack = data_done &&  gnt;

    assign m0_rdata = expire ? 32'hDEAD_BEEF : io_rdata;
    assign m1_rdata = expire ? 32'hDEAD_BEEF : io_rdata;

    assign busy        = (state != IDLE);
    assign timeout_err = expire;

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_io_arbiter;

    localparam int T = 8;
`ifdef IO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [3:0]  m0_wen = '0, m1_wen = '0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_req_ack, m0_data_ack, m1_req_ack, m1_data_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        io_req, io_wr;
    logic [3:0]  io_wen;
    logic [31:0] io_addr, io_wdata;
    logic        io_req_ack;
    logic        io_data_ack = 1'b0;
    logic [31:0] io_rdata = '0;
    logic        busy, timeout_err;
    logic        auto_ack = 1'b1;
    logic        ack_drv = 1'b0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Directed slave answers io_req in the same cycle; random slave acks at will.
    assign io_req_ack = auto_ack ? io_req : ack_drv;

    io_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_req_ack(m0_req_ack), .m0_data_ack(m0_data_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_req_ack(m1_req_ack), .m1_data_ack(m1_data_ack), .m1_rdata(m1_rdata),
        .io_req(io_req), .io_wr(io_wr), .io_wen(io_wen), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_req_ack(io_req_ack), .io_data_ack(io_data_ack), .io_rdata(io_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        chk32(name, 32'(act), 32'(exp));
    endfunction

    // Reference model: phase 0 = nobody served, 1 = owner asking slave, 2 = owner awaiting data.
    int ph = 0, own = 0, rr = 0, dc = 0;
    int n_ph = 0, n_own = 0, n_rr = 0, n_dc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0; own <= 0; rr <= 0; dc <= 0;
        end else begin
            ph <= n_ph; own <= n_own; rr <= n_rr; dc <= n_dc;
        end
    end

    always @(negedge clk) begin
        logic own_req, exp_ireq, expd;
        logic [1:0] ra, da;
        logic [31:0] exp_rd;
        own_req  = (own == 1) ? m1_req : m0_req;
        expd     = TO_EN && (ph == 2) && (dc == T) && !io_data_ack;
        exp_ireq = (ph == 1) && own_req;
        ra[0] = (ph == 1) && (own == 0) && io_req_ack;
        ra[1] = (ph == 1) && (own == 1) && io_req_ack;
        da[0] = (ph == 2) && (own == 0) && (io_data_ack || expd);
        da[1] = (ph == 2) && (own == 1) && (io_data_ack || expd);

        chk1("io_req", io_req, exp_ireq);
        chk1("m0_req_ack", m0_req_ack, ra[0]);
        chk1("m1_req_ack", m1_req_ack, ra[1]);
        chk1("m0_data_ack", m0_data_ack, da[0]);
        chk1("m1_data_ack", m1_data_ack, da[1]);
        chk1("busy", busy, ph != 0);
        chk1("timeout_err", timeout_err, expd);
        if (exp_ireq) begin
            chk1("io_wr", io_wr, (own == 1) ? m1_wr : m0_wr);
            chk32("io_wen", 32'(io_wen), 32'((own == 1) ? m1_wen : m0_wen));
            chk32("io_addr", io_addr, (own == 1) ? m1_addr : m0_addr);
            chk32("io_wdata", io_wdata, (own == 1) ? m1_wdata : m0_wdata);
        end
        if (da != 2'b00) begin
            exp_rd = expd ? 32'hDEAD_BEEF : io_rdata;
            chk32("m0_rdata", m0_rdata, exp_rd);
            chk32("m1_rdata", m1_rdata, exp_rd);
            $display("txn m%0d rdata=%h timeout=%0d t=%0t", own, exp_rd, expd, $time);
        end

        n_ph = ph; n_own = own; n_rr = rr; n_dc = dc;
        if (rst) begin
            n_ph = 0; n_own = 0; n_rr = 0; n_dc = 0;
        end else if (ph == 0) begin
            if (m0_req || m1_req) begin
                n_own = (m0_req && m1_req) ? rr : (m1_req ? 1 : 0);
                n_ph  = 1;
            end
        end else if (ph == 1) begin
            if (own_req && io_req_ack) begin
                n_ph = 2; n_dc = 1;
            end else if (!own_req) begin
                n_ph = 0;
            end
        end else begin
            if (io_data_ack || expd) begin
                n_ph = 0; n_rr = 1 - own;
            end else begin
                n_dc = dc + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that entered DATA; completes the granted master's transfer.
    task automatic finish_data(input int n, input logic [31:0] d);
        io_data_ack = 1'b1;
        io_rdata    = d;
        @(negedge clk);
        chk1("fd_data_ack_own", (n == 1) ? m1_data_ack : m0_data_ack, 1'b1);
        chk1("fd_data_ack_other", (n == 1) ? m0_data_ack : m1_data_ack, 1'b0);
        chk32("fd_rdata", (n == 1) ? m1_rdata : m0_rdata, d);
        tick();
        io_data_ack = 1'b0;
    endtask

    initial begin
        logic a0, a1;
        repeat (3) @(negedge clk);
        chk1("rst_io_req", io_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timeout", timeout_err, 1'b0);
        chk1("rst_m0_req_ack", m0_req_ack, 1'b0);
        tick();
        rst = 1'b0;

        // Single read by m0
        tick();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'hF000_0010;
        @(negedge clk);
        chk1("rd_early_ack", m0_req_ack, 1'b0);
        tick();
        @(negedge clk);
        chk1("rd_io_req", io_req, 1'b1);
        chk1("rd_m0_req_ack", m0_req_ack, 1'b1);
        chk1("rd_m1_req_ack", m1_req_ack, 1'b0);
        chk32("rd_io_addr", io_addr, 32'hF000_0010);
        tick();
        m0_req = 1'b0;
        finish_data(0, 32'h1234_5678);
        @(negedge clk);
        chk1("rd_idle_busy", busy, 1'b0);

        // Simultaneous requests from reset, then m1 wins the next tie
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        @(negedge clk);
        chk1("dual_m0_first", m0_req_ack, 1'b1);
        chk1("dual_m1_wait", m1_req_ack, 1'b0);
        tick();
        m0_req = 1'b0;
        finish_data(0, 32'hA5A5_0000);
        m0_req = 1'b1;
        @(negedge clk);
        chk1("dual_gap_busy", busy, 1'b0);
        chk1("dual_gap_m1_ack", m1_req_ack, 1'b0);
        tick();
        @(negedge clk);
        chk1("dual_m1_second", m1_req_ack, 1'b1);
        chk1("dual_m0_waits", m0_req_ack, 1'b0);
        tick();
        m1_req = 1'b0;
        finish_data(1, 32'h5A5A_0001);
        tick();
        @(negedge clk);
        chk1("dual_m0_third", m0_req_ack, 1'b1);
        tick();
        m0_req = 1'b0;
        finish_data(0, 32'h0BAD_F00D);

        // Write routing from m1, slave holds off its ack one cycle
        auto_ack = 1'b0; ack_drv = 1'b0;
        m1_req = 1'b1; m1_wr = 1'b1; m1_wen = 4'b0011;
        m1_addr = 32'hF000_0004; m1_wdata = 32'h0000_ABCD;
        tick();
        @(negedge clk);
        chk1("wr_io_req", io_req, 1'b1);
        chk1("wr_io_wr", io_wr, 1'b1);
        chk32("wr_io_wen", 32'(io_wen), 32'h3);
        chk32("wr_io_addr", io_addr, 32'hF000_0004);
        chk32("wr_io_wdata", io_wdata, 32'h0000_ABCD);
        tick();
        ack_drv = 1'b1;
        @(negedge clk);
        chk1("wr_m1_req_ack", m1_req_ack, 1'b1);
        tick();
        m1_req = 1'b0; ack_drv = 1'b0; auto_ack = 1'b1;
        finish_data(1, 32'h0);

        // Reset while waiting for data
        m0_req = 1'b1; m0_wr = 1'b0;
        tick();
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk1("mid_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        io_data_ack = 1'b1;
        #1;
        chk1("mid_async_busy", busy, 1'b0);
        chk1("mid_async_io_req", io_req, 1'b0);
        chk1("mid_async_m0_dack", m0_data_ack, 1'b0);
        chk1("mid_async_m1_dack", m1_data_ack, 1'b0);
        tick();
        rst = 1'b0;
        io_data_ack = 1'b0;
        m1_req = 1'b1; m1_wr = 1'b0;
        tick();
        @(negedge clk);
        chk1("post_rst_m1_ack", m1_req_ack, 1'b1);
        chk1("post_rst_m0_ack", m0_req_ack, 1'b0);
        tick();
        m1_req = 1'b0;
        finish_data(1, 32'hC0DE_0001);

        // Slave never answers the data phase
        m0_req = 1'b1;
        tick();
        tick();
        m0_req = 1'b0;
        if (TO_EN) begin
            for (int k = 1; k <= T; k++) begin
                @(negedge clk);
                chk1("to_err", timeout_err, k == T);
                chk1("to_m0_dack", m0_data_ack, k == T);
                if (k == T) begin
                    chk32("to_rdata", m0_rdata, 32'hDEAD_BEEF);
                    chk1("to_m1_dack", m1_data_ack, 1'b0);
                end
                tick();
            end
            @(negedge clk);
            chk1("to_idle", busy, 1'b0);
            chk1("to_err_clear", timeout_err, 1'b0);
        end else begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                chk1("nto_busy", busy, 1'b1);
                chk1("nto_err", timeout_err, 1'b0);
                tick();
            end
            finish_data(0, 32'h7777_0000);
        end

        // Random traffic against the model
        auto_ack = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            a0 = m0_req_ack;
            a1 = m1_req_ack;
            tick();
            if (m0_req) begin
                if (a0 || $urandom_range(0, 31) == 0) m0_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                m0_req = 1'b1; m0_wr = 1'($urandom_range(0, 1));
                m0_wen = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            end
            if (m1_req) begin
                if (a1 || $urandom_range(0, 31) == 0) m1_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                m1_req = 1'b1; m1_wr = 1'($urandom_range(0, 1));
                m1_wen = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            end
            ack_drv     = 1'($urandom_range(0, 1));
            io_data_ack = ($urandom_range(0, 3) == 0);
            io_rdata    = $urandom;
            rst         = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
